// File: rtl/i2c_target.sv
// I2C target: 7-bit address match, NUM_BYTES-byte write receive and read transmit.
// Define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample majority filter on SCL/SDA.
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         NUM_BYTES   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   scl,
    input  logic                   sda_in,
    output logic                   sda_out,
    input  logic [8*NUM_BYTES-1:0] data_snt,
    output logic [8*NUM_BYTES-1:0] data_rcv,
    output logic                   rcv_valid,
    output logic                   busy
);

    localparam int W   = 8 * NUM_BYTES;
    localparam int BCW = $clog2(NUM_BYTES + 1);
    localparam logic [BCW-1:0] LAST = BCW'(NUM_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } state_t;

    state_t           state;
    logic [1:0]       scl_sync;
    logic [1:0]       sda_sync;
    logic             scl_f;
    logic             sda_f;
    logic             scl_q;
    logic             sda_q;
    logic             scl_rise;
    logic             scl_fall;
    logic             start_det;
    logic             stop_det;
    logic [W-1:0]     rx_shift;
    logic [W-1:0]     tx_shift;
    logic [3:0]       bit_cnt;
    logic [BCW-1:0]   byte_cnt;
    logic             rw;
    logic             ack_ok;
    logic             addr_hit;

    // Bus idles high, so synchronisers reset to 1 to avoid a false START.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda_in};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_hist;
    logic [1:0] sda_hist;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
            scl_f    <= maj3(scl_sync[1], scl_hist[0], scl_hist[1]);
            sda_f    <= maj3(sda_sync[1], sda_hist[0], sda_hist[1]);
        end
    end
`else
    assign scl_f = scl_sync[1];
    assign sda_f = sda_sync[1];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;
    assign start_det = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
    assign addr_hit  = (rx_shift[7:1] == TARGET_ADDR) && (rx_shift[7:1] != 7'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sda_out   <= 1'b1;
            data_rcv  <= '0;
            rcv_valid <= 1'b0;
            busy      <= 1'b0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            rw        <= 1'b0;
            ack_ok    <= 1'b0;
        end else begin
            rcv_valid <= 1'b0;
            if (start_det) begin
                state    <= ADDR;
                busy     <= 1'b1;
                sda_out  <= 1'b1;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                rx_shift <= '0;
            end else if (stop_det) begin
                state   <= IDLE;
                busy    <= 1'b0;
                sda_out <= 1'b1;
            end else begin
                unique case (state)
                    IDLE, WAIT_STOP: begin
                    end
                    ADDR: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            rx_shift <= {rx_shift[W-2:0], sda_f};
                            bit_cnt  <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            rw <= rx_shift[0];
                            if (addr_hit) begin
                                sda_out <= 1'b0;
                                state   <= ADDR_ACK;
                                if (rx_shift[0]) tx_shift <= data_snt;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (rw) begin
                                sda_out  <= tx_shift[W-1];
                                tx_shift <= {tx_shift[W-2:0], 1'b0};
                                state    <= RD_DATA;
                            end else begin
                                sda_out <= 1'b1;
                                state   <= WR_DATA;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            rx_shift <= {rx_shift[W-2:0], sda_f};
                            bit_cnt  <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7 && byte_cnt != LAST)
                                byte_cnt <= byte_cnt + BCW'(1);
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_out <= 1'b0;
                            state   <= WR_ACK;
                        end
                    end
                    WR_ACK: begin
                        if (scl_rise && byte_cnt == LAST) begin
                            data_rcv  <= rx_shift;
                            rcv_valid <= 1'b1;
                        end else if (scl_fall) begin
                            sda_out <= 1'b1;
                            bit_cnt <= '0;
                            state   <= (byte_cnt == LAST) ? WAIT_STOP : WR_DATA;
                        end
                    end
                    RD_DATA: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7 && byte_cnt != LAST)
                                byte_cnt <= byte_cnt + BCW'(1);
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_out <= 1'b1;
                                state   <= RD_ACK;
                            end else begin
                                sda_out  <= tx_shift[W-1];
                                tx_shift <= {tx_shift[W-2:0], 1'b0};
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            ack_ok <= ~sda_f;
                        end else if (scl_fall) begin
                            if (ack_ok && byte_cnt != LAST) begin
                                bit_cnt  <= '0;
                                sda_out  <= tx_shift[W-1];
                                tx_shift <= {tx_shift[W-2:0], 1'b0};
                                state    <= RD_DATA;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: table of bus transfers plus hand-written corner sequences.
module tb_i2c_target;

    localparam int H = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        c_scl = 1'b1;
    logic        c_sda = 1'b1;
    logic        sda_out;
    logic        sda_bus;
    logic [23:0] data_snt = '0;
    logic [23:0] data_rcv;
    logic        rcv_valid;
    logic        busy;

    int ntests = 0;
    int nfail  = 0;
    int vcnt   = 0;

    assign sda_bus = c_sda & sda_out;

    i2c_target #(.TARGET_ADDR(7'h42), .NUM_BYTES(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl      (c_scl),
        .sda_in   (sda_bus),
        .sda_out  (sda_out),
        .data_snt (data_snt),
        .data_rcv (data_rcv),
        .rcv_valid(rcv_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rcv_valid) vcnt <= vcnt + 1;

    typedef struct {
        logic        rd;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          nb;
        logic [3:0]  mack;
        logic [23:0] snt;
        logic        e_aack;
        logic [3:0]  e_dack;
        int          e_valid;
        logic [23:0] e_rcv;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[10];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clk_bit(input logic b, input logic glitch, output logic smp);
        c_scl = 1'b0;
        tick(4);
        c_sda = b;
        if (glitch) begin
            tick(3);
            c_scl = 1'b1;
            tick(1);
            c_scl = 1'b0;
            tick(H - 8);
        end else begin
            tick(H - 4);
        end
        c_scl = 1'b1;
        tick(H / 2);
        smp = sda_bus;
        tick(H - H / 2);
    endtask

    task automatic do_start();
        c_scl = 1'b0;
        tick(4);
        c_sda = 1'b1;
        tick(H);
        c_scl = 1'b1;
        tick(H);
        c_sda = 1'b0;
        tick(H);
    endtask

    task automatic do_stop();
        c_scl = 1'b0;
        tick(4);
        c_sda = 1'b0;
        tick(H);
        c_scl = 1'b1;
        tick(H);
        c_sda = 1'b1;
        tick(H);
    endtask

    task automatic send_byte(input logic [7:0] d, input int gbit, output logic ack);
        logic s;
        for (int i = 0; i < 8; i++) clk_bit(d[7-i], gbit == i, s);
        clk_bit(1'b1, 1'b0, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] d);
        logic s;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            clk_bit(1'b1, 1'b0, s);
            d = {d[6:0], s};
        end
        clk_bit(~ack, 1'b0, s);
    endtask

    task automatic run_xfer(input vec_t v, output logic aack, output logic [3:0] dack,
                            output logic [31:0] rdata, output logic busy_mid);
        logic       a;
        logic [7:0] d;
        dack  = '0;
        rdata = '0;
        do_start();
        busy_mid = busy;
        send_byte(v.addr, -1, aack);
        for (int i = 0; i < v.nb; i++) begin
            if (v.rd) begin
                recv_byte(v.mack[i], d);
                rdata[31-8*i -: 8] = d;
            end else begin
                send_byte(v.wdata[31-8*i -: 8], -1, a);
                dack[i] = a;
            end
        end
        do_stop();
    endtask

    initial begin
        logic        aack;
        logic        a1;
        logic        a2;
        logic        a3;
        logic [3:0]  dack;
        logic [31:0] rdata;
        logic [7:0]  d;
        logic        bm;
        int          vb;
        logic        glitch_ok;
        logic        exp_ok;

        vecs[0] = '{1'b0, 8'h84, 32'hA53C7E00, 3, 4'b0000, 24'h000000,
                    1'b1, 4'b0111, 1, 24'hA53C7E, 32'h00000000};
        vecs[1] = '{1'b1, 8'h85, 32'h0, 3, 4'b0011, 24'h81F00F,
                    1'b1, 4'b0000, 0, 24'hA53C7E, 32'h81F00F00};
        vecs[2] = '{1'b0, 8'h86, 32'h11223300, 3, 4'b0000, 24'h000000,
                    1'b0, 4'b0000, 0, 24'hA53C7E, 32'h00000000};
        vecs[3] = '{1'b0, 8'h00, 32'h55000000, 1, 4'b0000, 24'h000000,
                    1'b0, 4'b0000, 0, 24'hA53C7E, 32'h00000000};
        vecs[4] = '{1'b0, 8'h84, 32'h1234569A, 4, 4'b0000, 24'h000000,
                    1'b1, 4'b0111, 1, 24'h123456, 32'h00000000};
        vecs[5] = '{1'b0, 8'h84, 32'hFF000000, 1, 4'b0000, 24'h000000,
                    1'b1, 4'b0001, 0, 24'h123456, 32'h00000000};
        vecs[6] = '{1'b1, 8'h85, 32'h0, 3, 4'b0111, 24'h5AC33C,
                    1'b1, 4'b0000, 0, 24'h123456, 32'h5AC33C00};
        vecs[7] = '{1'b1, 8'h85, 32'h0, 2, 4'b0000, 24'hE71818,
                    1'b1, 4'b0000, 0, 24'h123456, 32'hE7FF0000};
        vecs[8] = '{1'b1, 8'h87, 32'h0, 1, 4'b0000, 24'h123456,
                    1'b0, 4'b0000, 0, 24'h123456, 32'hFF000000};
        vecs[9] = '{1'b1, 8'h85, 32'h0, 4, 4'b0111, 24'h0F0F0F,
                    1'b1, 4'b0000, 0, 24'h123456, 32'h0F0F0FFF};

        tick(5);
        check("reset sda_out", {31'd0, sda_out}, 32'd1);
        check("reset data_rcv", {8'd0, data_rcv}, 32'd0);
        check("reset rcv_valid", {31'd0, rcv_valid}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        tick(5);

        for (int i = 0; i < 10; i++) begin
            data_snt = vecs[i].snt;
            vb = vcnt;
            run_xfer(vecs[i], aack, dack, rdata, bm);
            tick(10);
            check($sformatf("v%0d addr_ack", i), {31'd0, aack}, {31'd0, vecs[i].e_aack});
            check($sformatf("v%0d data_ack", i), {28'd0, dack}, {28'd0, vecs[i].e_dack});
            check($sformatf("v%0d valid_pulses", i), vcnt - vb, vecs[i].e_valid);
            check($sformatf("v%0d data_rcv", i), {8'd0, data_rcv}, {8'd0, vecs[i].e_rcv});
            check($sformatf("v%0d read_data", i), rdata, vecs[i].e_rd);
            check($sformatf("v%0d busy_mid", i), {31'd0, bm}, 32'd1);
            check($sformatf("v%0d busy_end", i), {31'd0, busy}, 32'd0);
        end

        // Partial write, repeated START, then read; data_snt changed after capture.
        data_snt = 24'hC0FFEE;
        vb = vcnt;
        do_start();
        send_byte(8'h84, -1, a1);
        send_byte(8'h11, -1, a2);
        do_start();
        send_byte(8'h85, -1, a3);
        data_snt = 24'h000000;
        rdata = '0;
        for (int i = 0; i < 3; i++) begin
            recv_byte(i != 2, d);
            rdata[31-8*i -: 8] = d;
        end
        do_stop();
        tick(10);
        check("rs write addr ack", {31'd0, a1}, 32'd1);
        check("rs write data ack", {31'd0, a2}, 32'd1);
        check("rs read addr ack", {31'd0, a3}, 32'd1);
        check("rs read data", rdata, 32'hC0FFEE00);
        check("rs no valid", vcnt - vb, 0);
        check("rs data_rcv kept", {8'd0, data_rcv}, 32'h00123456);
        check("rs busy_end", {31'd0, busy}, 32'd0);

        // Reset while the target drives a 0 data bit.
        data_snt = 24'h3C0000;
        do_start();
        send_byte(8'h85, -1, a1);
        check("rr addr ack", {31'd0, a1}, 32'd1);
        c_scl = 1'b0;
        tick(8);
        check("rr driving low", {31'd0, sda_out}, 32'd0);
        rst = 1'b0;
        #1;
        check("rr sda released", {31'd0, sda_out}, 32'd1);
        check("rr busy clear", {31'd0, busy}, 32'd0);
        check("rr data_rcv clear", {8'd0, data_rcv}, 32'd0);
        tick(2);
        c_sda = 1'b1;
        c_scl = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(4);
        send_byte(8'h84, -1, a2);
        check("rr no ack w/o start", {31'd0, a2}, 32'd0);
        check("rr idle busy", {31'd0, busy}, 32'd0);
        do_stop();
        tick(10);

        // One-clock SCL glitch inside the first data byte.
        vb = vcnt;
        do_start();
        send_byte(8'h84, -1, a1);
        send_byte(8'hA5, 3, a2);
        send_byte(8'h3C, -1, a2);
        send_byte(8'h7E, -1, a2);
        do_stop();
        tick(10);
        glitch_ok = (vcnt - vb == 1) && (data_rcv == 24'hA53C7E);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        exp_ok = 1'b1;
`else
        exp_ok = 1'b0;
`endif
        check("glitch write intact", {31'd0, glitch_ok}, {31'd0, exp_ok});

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
